// File: rtl/dcache_ctrl_nway.sv
// ---------------------------------------------------------------------------
// dcache_ctrl_nway
//   N-way set-associative write-back data cache controller with true-LRU
//   replacement (per-entry age counters), a whole-cache flush walker and a
//   combinational IO bypass for addresses with cpu_addr[IO_BIT] set.
//
// Ports
//   clk, rst_n       clock; asynchronous active-low reset
//   cpu_addr/wdata   CPU word address / write data
//   cpu_rw           1 = write, 0 = read
//   cpu_valid        request strobe (sampled in IDLE only)
//   flush            with cpu_valid: write back and invalidate the whole cache
//   cpu_rdata/ready  read data / one-cycle completion pulse
//   mem_*            line-wide backing memory port (valid/ready handshake,
//                    mem_ready is a one-cycle pulse)
//   io_*             uncached word port, driven straight from the CPU side
// ---------------------------------------------------------------------------
module dcache_ctrl_nway #(
   parameter int NUM_WAYS       = 4,
   parameter int NUM_SETS       = 64,
   parameter int WORDS_PER_LINE = 8,
   parameter int ADDR_WIDTH     = 28,
   parameter int DATA_WIDTH     = 32,
   parameter int IO_BIT         = ADDR_WIDTH - 1
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   // CPU side
   input  logic [ADDR_WIDTH-1:0]                cpu_addr,
   input  logic [DATA_WIDTH-1:0]                cpu_wdata,
   input  logic                                 cpu_rw,
   input  logic                                 cpu_valid,
   input  logic                                 flush,
   output logic [DATA_WIDTH-1:0]                cpu_rdata,
   output logic                                 cpu_ready,
   // memory side
   output logic [ADDR_WIDTH-1:0]                mem_addr,
   output logic [DATA_WIDTH*WORDS_PER_LINE-1:0] mem_wdata,
   output logic                                 mem_rw,
   output logic                                 mem_valid,
   input  logic [DATA_WIDTH*WORDS_PER_LINE-1:0] mem_rdata,
   input  logic                                 mem_ready,
   // IO bypass side
   output logic [ADDR_WIDTH-1:0]                io_addr,
   output logic [DATA_WIDTH-1:0]                io_wdata,
   output logic                                 io_rw,
   output logic                                 io_valid,
   input  logic [DATA_WIDTH-1:0]                io_rdata,
   input  logic                                 io_ready
);

   localparam int OFF_W  = $clog2(WORDS_PER_LINE);
   localparam int IDX_W  = $clog2(NUM_SETS);
   localparam int WAY_W  = $clog2(NUM_WAYS);
   localparam int TAG_W  = ADDR_WIDTH - IDX_W - OFF_W;
   localparam int LINE_W = DATA_WIDTH * WORDS_PER_LINE;
   localparam int ENT_W  = IDX_W + WAY_W;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOOKUP,
      ST_WRITE_BACK,
      ST_ALLOCATE,
      ST_REFILL,
      ST_FLUSH_SCAN,
      ST_FLUSH_WB
   } state_t;

   // ---------------- registers ----------------
   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic                  r_rw;
   logic [WAY_W-1:0]      r_victim;
   logic [ENT_W-1:0]      r_fcnt;     // flush walker: {set, way}

   logic [NUM_SETS-1:0]   r_valid [NUM_WAYS];
   logic [NUM_SETS-1:0]   r_dirty [NUM_WAYS];
   logic [WAY_W-1:0]      r_age   [NUM_WAYS][NUM_SETS];
   logic [TAG_W-1:0]      r_tag   [NUM_WAYS][NUM_SETS];
   logic [LINE_W-1:0]     r_line  [NUM_WAYS][NUM_SETS];

   // ---------------- wires ----------------
   state_t                w_next_state;
   logic [IDX_W-1:0]      w_idx;
   logic [OFF_W-1:0]      w_off;
   logic [TAG_W-1:0]      w_req_tag;
   logic                  w_io;

   logic                  w_hit;
   logic [WAY_W-1:0]      w_hit_way;
   logic [DATA_WIDTH-1:0] w_hit_word;

   logic [WAY_W-1:0]      w_victim;
   logic                  w_found;
   logic [WAY_W-1:0]      w_max_age;
   logic                  w_victim_dirty;

   logic [IDX_W-1:0]      w_f_set;
   logic [WAY_W-1:0]      w_f_way;
   logic                  w_f_last;
   logic                  w_f_dirty;

   logic                  w_accept;
   logic                  w_hit_wr;
   logic                  w_miss;
   logic                  w_touch;
   logic [WAY_W-1:0]      w_touch_way;
   logic [WAY_W-1:0]      w_old_age;
   logic                  w_fill;
   logic                  w_f_clear;
   logic                  w_flush_done;

   // ---------------- address decode ----------------
   assign w_io      = cpu_addr[IO_BIT];
   assign w_off     = r_addr[OFF_W-1:0];
   assign w_idx     = r_addr[OFF_W +: IDX_W];
   assign w_req_tag = r_addr[ADDR_WIDTH-1 -: TAG_W];

   assign w_f_set   = r_fcnt[ENT_W-1:WAY_W];
   assign w_f_way   = r_fcnt[WAY_W-1:0];
   assign w_f_last  = &r_fcnt;
   assign w_f_dirty = r_valid[w_f_way][w_f_set] & r_dirty[w_f_way][w_f_set];

   // ---------------- tag compare ----------------
   // NOTE: every signal written in an always_comb gets a default at the top;
   // otherwise a path that skips the assignment infers a latch.
   always_comb begin
      w_hit     = 1'b0;
      w_hit_way = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (!w_hit && r_valid[w][w_idx] && (r_tag[w][w_idx] == w_req_tag)) begin
            w_hit     = 1'b1;
            w_hit_way = WAY_W'(w);
         end
      end
   end

   assign w_hit_word = r_line[w_hit_way][w_idx][w_off*DATA_WIDTH +: DATA_WIDTH];

   // ---------------- victim selection ----------------
   // Lowest invalid way first; with a full set the oldest way (max age).
   always_comb begin
      w_victim  = '0;
      w_found   = 1'b0;
      w_max_age = r_age[0][w_idx];
      for (int w = 0; w < NUM_WAYS; w++) begin
         if (!w_found && !r_valid[w][w_idx]) begin
            w_victim = WAY_W'(w);
            w_found  = 1'b1;
         end
      end
      if (!w_found) begin
         for (int w = 1; w < NUM_WAYS; w++) begin
            if (r_age[w][w_idx] > w_max_age) begin
               w_max_age = r_age[w][w_idx];
               w_victim  = WAY_W'(w);
            end
         end
      end
   end

   assign w_victim_dirty = r_valid[w_victim][w_idx] & r_dirty[w_victim][w_idx];
   assign w_old_age      = r_age[w_touch_way][w_idx];

   // ---------------- FSM: next state and outputs ----------------
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_hit_wr     = 1'b0;
      w_miss       = 1'b0;
      w_touch      = 1'b0;
      w_touch_way  = '0;
      w_fill       = 1'b0;
      w_f_clear    = 1'b0;
      w_flush_done = 1'b0;
      cpu_rdata    = '0;
      cpu_ready    = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      mem_rw       = 1'b0;
      mem_valid    = 1'b0;
      io_addr      = '0;
      io_wdata     = '0;
      io_rw        = 1'b0;
      io_valid     = 1'b0;

      // Outputs go quiet the moment reset asserts, even mid-transaction.
      if (rst_n) begin
         case (r_state)
            ST_IDLE: begin
               if (w_io) begin
                  // Uncached access: pure wiring, FSM never leaves IDLE.
                  io_addr   = cpu_addr;
                  io_wdata  = cpu_wdata;
                  io_rw     = cpu_rw;
                  io_valid  = cpu_valid;
                  cpu_rdata = io_rdata;
                  cpu_ready = io_ready;
               end else if (cpu_valid) begin
                  w_accept     = 1'b1;
                  w_next_state = flush ? ST_FLUSH_SCAN : ST_LOOKUP;
               end
            end

            ST_LOOKUP: begin
               if (w_hit) begin
                  cpu_ready    = 1'b1;
                  cpu_rdata    = r_rw ? '0 : w_hit_word;
                  w_hit_wr     = r_rw;
                  w_touch      = 1'b1;
                  w_touch_way  = w_hit_way;
                  w_next_state = ST_IDLE;
               end else begin
                  w_miss       = 1'b1;
                  w_next_state = w_victim_dirty ? ST_WRITE_BACK : ST_ALLOCATE;
               end
            end

            ST_WRITE_BACK: begin
               mem_valid = 1'b1;
               mem_rw    = 1'b1;
               mem_addr  = {r_tag[r_victim][w_idx], w_idx, {OFF_W{1'b0}}};
               mem_wdata = r_line[r_victim][w_idx];
               if (mem_ready) w_next_state = ST_ALLOCATE;
            end

            ST_ALLOCATE: begin
               mem_valid = 1'b1;
               mem_addr  = {w_req_tag, w_idx, {OFF_W{1'b0}}};
               if (mem_ready) begin
                  w_fill       = 1'b1;
                  w_touch      = 1'b1;
                  w_touch_way  = r_victim;
                  w_next_state = ST_REFILL;
               end
            end

            // One settling cycle; the re-run lookup then hits the new line.
            ST_REFILL: w_next_state = ST_LOOKUP;

            ST_FLUSH_SCAN: begin
               if (w_f_dirty) begin
                  w_next_state = ST_FLUSH_WB;
               end else begin
                  w_f_clear = 1'b1;
                  if (w_f_last) begin
                     cpu_ready    = 1'b1;
                     w_flush_done = 1'b1;
                     w_next_state = ST_IDLE;
                  end
               end
            end

            ST_FLUSH_WB: begin
               mem_valid = 1'b1;
               mem_rw    = 1'b1;
               mem_addr  = {r_tag[w_f_way][w_f_set], w_f_set, {OFF_W{1'b0}}};
               mem_wdata = r_line[w_f_way][w_f_set];
               if (mem_ready) begin
                  w_f_clear = 1'b1;
                  if (w_f_last) begin
                     cpu_ready    = 1'b1;
                     w_flush_done = 1'b1;
                     w_next_state = ST_IDLE;
                  end else begin
                     w_next_state = ST_FLUSH_SCAN;
                  end
               end
            end

            default: w_next_state = ST_IDLE;
         endcase
      end
   end

   // ---------------- FSM state and request registers ----------------
   // NOTE: sequential state is assigned with <= so every flop samples the
   // pre-edge values; blocking = here would create order-dependent races.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_rw     <= 1'b0;
         r_victim <= '0;
         r_fcnt   <= '0;
      end else begin
         r_state <= w_next_state;
         if (w_accept) begin
            r_addr  <= cpu_addr;
            r_wdata <= cpu_wdata;
            r_rw    <= cpu_rw;
         end
         if (w_accept && flush) r_fcnt <= '0;
         else if (w_f_clear)    r_fcnt <= r_fcnt + ENT_W'(1);
         // Victim is frozen at miss time; ages do not move until the fill.
         if (w_miss) r_victim <= w_victim;
      end
   end

   // ---------------- status bits and LRU ages ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int w = 0; w < NUM_WAYS; w++) begin
            r_valid[w] <= '0;
            r_dirty[w] <= '0;
            for (int s = 0; s < NUM_SETS; s++) r_age[w][s] <= WAY_W'(w);
         end
      end else begin
         if (w_hit_wr) r_dirty[w_hit_way][w_idx] <= 1'b1;
         if (w_fill) begin
            r_valid[r_victim][w_idx] <= 1'b1;
            r_dirty[r_victim][w_idx] <= 1'b0;
         end
         if (w_f_clear) begin
            r_valid[w_f_way][w_f_set] <= 1'b0;
            r_dirty[w_f_way][w_f_set] <= 1'b0;
         end
         if (w_flush_done) begin
            for (int w = 0; w < NUM_WAYS; w++)
               for (int s = 0; s < NUM_SETS; s++) r_age[w][s] <= WAY_W'(w);
         end else if (w_touch) begin
            // Touched way becomes youngest; only ways younger than it age,
            // so each set keeps a permutation of 0..NUM_WAYS-1.
            for (int w = 0; w < NUM_WAYS; w++) begin
               if (WAY_W'(w) == w_touch_way)
                  r_age[w][w_idx] <= '0;
               else if (r_age[w][w_idx] < w_old_age)
                  r_age[w][w_idx] <= r_age[w][w_idx] + WAY_W'(1);
            end
         end
      end
   end

   // ---------------- tag and line storage ----------------
   // NOTE: tag and line arrays carry no reset; the valid bits gate every use,
   // and an unreset array can be mapped onto RAM.
   always_ff @(posedge clk) begin
      if (w_fill) begin
         r_tag[r_victim][w_idx]  <= w_req_tag;
         r_line[r_victim][w_idx] <= mem_rdata;
      end
      if (w_hit_wr) r_line[w_hit_way][w_idx][w_off*DATA_WIDTH +: DATA_WIDTH] <= r_wdata;
   end

endmodule

// File: tb/tb_dcache_ctrl_nway.sv
// ---------------------------------------------------------------------------
// tb_dcache_ctrl_nway
//   Directed bench for dcache_ctrl_nway with default parameters
//   (4 ways, 64 sets, 8 words/line, 28-bit word address, IO bit 27).
//   Inputs change on the falling edge; outputs are sampled on the falling
//   edge or 1 time unit after a rising edge.
// ---------------------------------------------------------------------------
module tb_dcache_ctrl_nway;

   localparam int AW  = 28;
   localparam int DW  = 32;
   localparam int WPL = 8;
   localparam int LW  = DW * WPL;
   localparam int NS  = 64;
   localparam int NW  = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_rw;
   logic          cpu_valid;
   logic          flush;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_ready;
   logic [AW-1:0] mem_addr;
   logic [LW-1:0] mem_wdata;
   logic          mem_rw;
   logic          mem_valid;
   logic [LW-1:0] mem_rdata;
   logic          mem_ready;
   logic [AW-1:0] io_addr;
   logic [DW-1:0] io_wdata;
   logic          io_rw;
   logic          io_valid;
   logic [DW-1:0] io_rdata;
   logic          io_ready;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dcache_ctrl_nway dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rw    (cpu_rw),
      .cpu_valid (cpu_valid),
      .flush     (flush),
      .cpu_rdata (cpu_rdata),
      .cpu_ready (cpu_ready),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rw    (mem_rw),
      .mem_valid (mem_valid),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .io_addr   (io_addr),
      .io_wdata  (io_wdata),
      .io_rw     (io_rw),
      .io_valid  (io_valid),
      .io_rdata  (io_rdata),
      .io_ready  (io_ready)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [LW-1:0] mk_line(input logic [31:0] w0, input logic [31:0] base);
      logic [LW-1:0] l;
      for (int i = 0; i < WPL; i++) l[i*DW +: DW] = (i == 0) ? w0 : base + 32'(i);
      return l;
   endfunction

   // Present one request; returns 1 unit after the accepting rising edge.
   task automatic cpu_req(input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic rw, input logic fl);
      @(negedge clk);
      cpu_addr  = a;
      cpu_wdata = d;
      cpu_rw    = rw;
      flush     = fl;
      cpu_valid = 1'b1;
      @(posedge clk);
      #1;
      cpu_valid = 1'b0;
      flush     = 1'b0;
   endtask

   // Count falling edges until cpu_ready; n = -1 on timeout.
   task automatic wait_ready(output int n, output logic [DW-1:0] rd);
      n  = 0;
      rd = '0;
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         n++;
         if (cpu_ready) begin
            rd = cpu_rdata;
            return;
         end
      end
      n = -1;
   endtask

   // Wait for a memory request, check it, answer with a one-cycle mem_ready.
   task automatic service_mem(input string tag, input logic [AW-1:0] ea, input logic erw,
                              input logic [LW-1:0] rline, output logic [LW-1:0] wline);
      int k;
      k = 0;
      @(negedge clk);
      while (!mem_valid && k < 50) begin
         @(negedge clk);
         k++;
      end
      check({tag, " mem_valid"}, 64'(mem_valid), 64'd1);
      check({tag, " mem_addr"},  64'(mem_addr),  64'(ea));
      check({tag, " mem_rw"},    64'(mem_rw),    64'(erw));
      wline     = mem_wdata;
      mem_rdata = rline;
      mem_ready = 1'b1;
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int            n;
      int            wbs;
      logic [DW-1:0] rd;
      logic [LW-1:0] wl;
      logic [AW-1:0] bcd [3];

      rst_n     = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      cpu_rw    = 1'b0;
      cpu_valid = 1'b0;
      flush     = 1'b0;
      mem_rdata = '0;
      mem_ready = 1'b0;
      io_rdata  = '0;
      io_ready  = 1'b0;
      bcd[0]    = 28'h0000418;
      bcd[1]    = 28'h0000618;
      bcd[2]    = 28'h0000818;

      // ---------------- reset state ----------------
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst cpu_ready", 64'(cpu_ready), 64'd0);
      check("rst cpu_rdata", 64'(cpu_rdata), 64'd0);
      check("rst mem_valid", 64'(mem_valid), 64'd0);
      check("rst mem_addr",  64'(mem_addr),  64'd0);
      check("rst io_valid",  64'(io_valid),  64'd0);
      rst_n = 1'b1;

      // ---------------- cold read miss ----------------
      cpu_req(28'h0000100, '0, 1'b0, 1'b0);
      service_mem("cold alloc", 28'h0000100, 1'b0, mk_line(32'hA5A5A5A5, 32'h1000_0000), wl);
      @(negedge clk);
      check("refill mem_valid low", 64'(mem_valid), 64'd0);
      check("refill no ready",      64'(cpu_ready), 64'd0);
      wait_ready(n, rd);
      check("cold ready 2nd cycle", 64'(n),  64'd1);
      check("cold rdata",           64'(rd), 64'hA5A5A5A5);
      @(negedge clk);
      check("ready is a pulse", 64'(cpu_ready), 64'd0);

      // ---------------- write hit then read back ----------------
      cpu_req(28'h0000102, 32'hDEADBEEF, 1'b1, 1'b0);
      wait_ready(n, rd);
      check("wr hit latency",   64'(n),         64'd1);
      check("wr hit rdata 0",   64'(rd),        64'd0);
      check("wr hit mem quiet", 64'(mem_valid), 64'd0);
      cpu_req(28'h0000102, '0, 1'b0, 1'b0);
      wait_ready(n, rd);
      check("rd hit latency", 64'(n),  64'd1);
      check("rd hit rdata",   64'(rd), 64'hDEADBEEF);
      cpu_req(28'h0000100, '0, 1'b0, 1'b0);
      wait_ready(n, rd);
      check("rd word0 kept", 64'(rd), 64'hA5A5A5A5);
      cpu_req(28'h0000107, '0, 1'b0, 1'b0);
      wait_ready(n, rd);
      check("rd word7", 64'(rd), 64'h1000_0007);

      // ---------------- LRU eviction on set 3 ----------------
      cpu_req(28'h0000218, 32'h1111_2222, 1'b1, 1'b0);
      service_mem("A alloc", 28'h0000218, 1'b0, mk_line(32'h0A0A_0000, 32'h0A00_0000), wl);
      wait_ready(n, rd);
      check("A write miss latency", 64'(n),  64'd2);
      check("A write rdata 0",      64'(rd), 64'd0);
      for (int i = 0; i < 3; i++) begin
         cpu_req(bcd[i], '0, 1'b0, 1'b0);
         service_mem("BCD alloc", bcd[i], 1'b0, mk_line(32'hB0B0_0000 + 32'(i), 32'hB000_0000), wl);
         wait_ready(n, rd);
         check("BCD rdata", 64'(rd), 64'(32'hB0B0_0000 + 32'(i)));
      end
      cpu_req(28'h0000A18, '0, 1'b0, 1'b0);
      service_mem("E wb", 28'h0000218, 1'b1, '0, wl);
      check("E wb word0", 64'(wl[31:0]),  64'h1111_2222);
      check("E wb word1", 64'(wl[63:32]), 64'h0A00_0001);
      service_mem("E alloc", 28'h0000A18, 1'b0, mk_line(32'hEEEE_0000, 32'hE000_0000), wl);
      wait_ready(n, rd);
      check("E miss latency", 64'(n),  64'd2);
      check("E rdata",        64'(rd), 64'hEEEE_0000);
      cpu_req(28'h0000418, '0, 1'b0, 1'b0);
      wait_ready(n, rd);
      check("B still hits", 64'(n),  64'd1);
      check("B rdata",      64'(rd), 64'hB0B0_0000);
      cpu_req(28'h0000A19, 32'hCAFE_F00D, 1'b1, 1'b0);
      wait_ready(n, rd);
      check("E write hit latency", 64'(n), 64'd1);

      // ---------------- flush with two dirty lines ----------------
      cpu_req(28'h0000000, '0, 1'b0, 1'b1);
      n   = 0;
      wbs = 0;
      rd  = '0;
      while (rd == '0 && n < 2000) begin
         @(negedge clk);
         n++;
         mem_ready = mem_valid;
         if (mem_valid) begin
            wbs++;
            if (wbs == 1) begin
               check("flush wb1 addr",  64'(mem_addr),          64'h0000A18);
               check("flush wb1 rw",    64'(mem_rw),            64'd1);
               check("flush wb1 word1", 64'(mem_wdata[63:32]),  64'hCAFE_F00D);
            end else if (wbs == 2) begin
               check("flush wb2 addr",  64'(mem_addr),          64'h0000100);
               check("flush wb2 word0", 64'(mem_wdata[31:0]),   64'hA5A5A5A5);
               check("flush wb2 word2", 64'(mem_wdata[95:64]),  64'hDEADBEEF);
            end
         end
         if (cpu_ready) rd = 32'd1;
      end
      mem_ready = 1'b0;
      check("flush write-backs", 64'(wbs), 64'd2);
      check("flush cycles",      64'(n),   64'(NS * NW + 2));
      @(negedge clk);
      check("flush ready pulse", 64'(cpu_ready), 64'd0);

      cpu_req(28'h0000102, '0, 1'b0, 1'b0);
      service_mem("post-flush 100", 28'h0000100, 1'b0, mk_line(32'h5555_0000, 32'h5000_0000), wl);
      wait_ready(n, rd);
      check("post-flush rdata", 64'(rd), 64'h5000_0002);
      cpu_req(28'h0000A19, '0, 1'b0, 1'b0);
      service_mem("post-flush A18", 28'h0000A18, 1'b0, mk_line(32'h6666_0000, 32'h6000_0000), wl);
      wait_ready(n, rd);
      check("post-flush E rdata", 64'(rd), 64'h6000_0001);

      // ---------------- IO bypass ----------------
      @(negedge clk);
      cpu_addr  = 28'h8000004;
      cpu_rw    = 1'b0;
      cpu_valid = 1'b1;
      flush     = 1'b1;
      io_ready  = 1'b1;
      io_rdata  = 32'h1234_5678;
      #1;
      check("io valid",     64'(io_valid),  64'd1);
      check("io addr",      64'(io_addr),   64'h8000004);
      check("io rdata",     64'(cpu_rdata), 64'h1234_5678);
      check("io ready",     64'(cpu_ready), 64'd1);
      check("io mem quiet", 64'(mem_valid), 64'd0);
      cpu_rw    = 1'b1;
      cpu_wdata = 32'h8765_4321;
      #1;
      check("io rw",    64'(io_rw),    64'd1);
      check("io wdata", 64'(io_wdata), 64'h8765_4321);
      @(posedge clk);
      #1;
      cpu_valid = 1'b0;
      flush     = 1'b0;
      io_ready  = 1'b0;
      cpu_rw    = 1'b0;
      cpu_addr  = 28'h0000100;
      #1;
      check("io idle when bit low", 64'(io_valid),  64'd0);
      check("no ready after io",    64'(cpu_ready), 64'd0);
      cpu_req(28'h0000102, '0, 1'b0, 1'b0);
      wait_ready(n, rd);
      check("hit after io latency", 64'(n),  64'd1);
      check("hit after io rdata",   64'(rd), 64'h5000_0002);

      // ---------------- reset during ALLOCATE ----------------
      cpu_req(28'h0000300, '0, 1'b0, 1'b0);
      n = 0;
      @(negedge clk);
      while (!mem_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("alloc reached", 64'(mem_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      check("mid rst mem_valid", 64'(mem_valid), 64'd0);
      check("mid rst mem_addr",  64'(mem_addr),  64'd0);
      check("mid rst mem_rw",    64'(mem_rw),    64'd0);
      check("mid rst cpu_ready", 64'(cpu_ready), 64'd0);
      check("mid rst cpu_rdata", 64'(cpu_rdata), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cpu_req(28'h0000300, '0, 1'b0, 1'b0);
      service_mem("after rst 300", 28'h0000300, 1'b0, mk_line(32'h7777_0000, 32'h7000_0000), wl);
      wait_ready(n, rd);
      check("after rst latency", 64'(n),  64'd2);
      check("after rst rdata",   64'(rd), 64'h7777_0000);
      cpu_req(28'h0000102, '0, 1'b0, 1'b0);
      service_mem("after rst 100", 28'h0000100, 1'b0, mk_line(32'h8888_0000, 32'h8000_0000), wl);
      wait_ready(n, rd);
      check("after rst 100 rdata", 64'(rd), 64'h8000_0002);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
